sample_fetcher: RTL and testbench

Consumer-side partner of the sine sample generator. Drives the generator's `generate_next`/`sample_ready` handshake, keeps a small FIFO of signed 16-bit samples prefetched, and presents them to the codec-facing logic, which pops one sample per `codec_req` pulse. Sits between the note/sine generator and the codec conditioner. Absorbs generator latency and flags generator stalls and codec underflow.

---
 rtl/sample_fetcher_pkg.sv | 16 +
 rtl/sample_fifo.sv | 60 ++++++
 rtl/sample_fetcher.sv | 119 +++++++++++
 tb/tb_sample_fetcher.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sample_fetcher_pkg.sv
// Shared definitions for the sample fetcher.
//   SAMPLE_W       : generator/codec sample width
//   SILENCE        : sample pushed when the generator misses a response
//   fetch_state_t  : request FSM states (IDLE, WAIT)
package sample_fetcher_pkg;

  localparam int SAMPLE_W = 16;

  localparam logic [SAMPLE_W-1:0] SILENCE = 16'h0000;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } fetch_state_t;

endpackage

// File: rtl/sample_fifo.sv
// Small circular sample FIFO.
//   clk, reset  : clock, synchronous active-high reset (pointers/count only)
//   push        : write push_data at the tail (caller guarantees not full)
//   push_data   : sample to append
//   pop         : remove head; ignored while empty
//   head        : oldest stored entry (meaningful when count != 0)
//   count       : number of stored entries, 0..DEPTH
module sample_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             pop_ok;

  always_comb begin
    pop_ok = pop && (count != '0);
    head   = mem[rd_ptr];
  end

  // Storage carries no reset; only pointers and count define validity.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push, pop_ok})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/sample_fetcher.sv
// Prefetches signed samples from the sine generator into a small FIFO and
// hands them to the codec side one per codec_req pulse.
//   clk, reset     : clock, synchronous active-high reset
//   generate_next  : registered one-cycle request pulse to the generator
//   sample_ready   : generator response strobe (2 cycles after request)
//   sample         : generator sample, valid with sample_ready
//   codec_req      : one-cycle pop request from the codec side
//   codec_sample   : FIFO head while codec_valid, else zero
//   codec_valid    : FIFO non-empty
//   timeout_err    : one-cycle pulse, generator missed a response
//   underflow      : one-cycle pulse, codec_req while empty
module sample_fetcher
  import sample_fetcher_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 7
) (
  input  logic                clk,
  input  logic                reset,
  output logic                generate_next,
  input  logic                sample_ready,
  input  logic [SAMPLE_W-1:0] sample,
  input  logic                codec_req,
  output logic [SAMPLE_W-1:0] codec_sample,
  output logic                codec_valid,
  output logic                timeout_err,
  output logic                underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int TW = $clog2(TIMEOUT);
  localparam logic [AW:0]   FULL       = (AW+1)'(DEPTH);
  // Timer counts completed WAIT cycles; expiry is the TIMEOUT-th WAIT cycle.
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);

  fetch_state_t        state;
  fetch_state_t        state_d;
  logic [TW-1:0]       timer;
  logic [TW-1:0]       timer_d;
  logic                generate_next_d;
  logic                timeout_err_d;
  logic                underflow_d;
  logic                push;
  logic [SAMPLE_W-1:0] push_data;
  logic                pop;
  logic [SAMPLE_W-1:0] head;
  logic [AW:0]         count;

  sample_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (SAMPLE_W)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .head      (head),
    .count     (count)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      timer         <= '0;
      generate_next <= 1'b0;
      timeout_err   <= 1'b0;
      underflow     <= 1'b0;
    end else begin
      state         <= state_d;
      timer         <= timer_d;
      generate_next <= generate_next_d;
      timeout_err   <= timeout_err_d;
      underflow     <= underflow_d;
    end
  end

  always_comb begin
    state_d = state;
    case (state)
      IDLE: if (count < FULL) state_d = WAIT;
      WAIT: if (sample_ready || (timer == TIMER_LAST)) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // A real response wins over a simultaneous timeout expiry.
  always_comb begin
    generate_next_d = 1'b0;
    timeout_err_d   = 1'b0;
    push            = 1'b0;
    push_data       = sample;
    timer_d         = timer;
    case (state)
      IDLE: begin
        timer_d = '0;
        if (count < FULL) generate_next_d = 1'b1;
      end
      WAIT: begin
        if (sample_ready) begin
          push = 1'b1;
        end else if (timer == TIMER_LAST) begin
          push          = 1'b1;
          push_data     = SILENCE;
          timeout_err_d = 1'b1;
        end else begin
          timer_d = timer + TW'(1);
        end
      end
      default: timer_d = '0;
    endcase

    pop          = codec_req && (count != '0);
    underflow_d  = codec_req && (count == '0);
    codec_valid  = (count != '0);
    codec_sample = codec_valid ? head : SILENCE;
  end

endmodule

// File: tb/tb_sample_fetcher.sv
module tb_sample_fetcher;

  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 7;

  logic        clk = 1'b0;
  logic        reset;
  logic        generate_next;
  logic        sample_ready;
  logic [15:0] sample;
  logic        codec_req;
  logic [15:0] codec_sample;
  logic        codec_valid;
  logic        timeout_err;
  logic        underflow;

  always #5 clk = ~clk;

  sample_fetcher #(
    .DEPTH   (DEPTH),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .generate_next (generate_next),
    .sample_ready  (sample_ready),
    .sample        (sample),
    .codec_req     (codec_req),
    .codec_sample  (codec_sample),
    .codec_valid   (codec_valid),
    .timeout_err   (timeout_err),
    .underflow     (underflow)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- generator model (2-cycle latency) ----------------
  logic        gen_en = 1'b1;
  logic [15:0] gen_base = 16'h0001;
  int          gen_epoch = 0;
  logic        stray_fire = 1'b0;
  logic [15:0] stray_val = 16'h0000;
  logic        gn_m1 = 1'b0;
  logic        gn_m2 = 1'b0;
  int          gen_cnt = 0;
  int          gen_last_epoch = 0;

  initial begin
    sample_ready = 1'b0;
    sample       = 16'h0000;
  end

  always @(negedge clk) begin
    #1;
    if (gen_epoch != gen_last_epoch) begin
      gen_last_epoch = gen_epoch;
      gen_cnt        = 0;
    end
    if (stray_fire) begin
      sample_ready = 1'b1;
      sample       = stray_val;
    end else if (gn_m2 && gen_en) begin
      sample_ready = 1'b1;
      sample       = gen_base + 16'(gen_cnt);
      gen_cnt++;
    end else begin
      sample_ready = 1'b0;
      sample       = 16'h0000;
    end
    gn_m2 = gn_m1;
    gn_m1 = generate_next;
  end

  // ---------------- behavioural reference ----------------
  logic [15:0] q[$];
  logic        busy = 1'b0;
  int          waited = 0;
  logic        e_gn = 1'b0;
  logic        e_to = 1'b0;
  logic        e_uf = 1'b0;
  logic        m_push;
  logic [15:0] m_val;
  int          occ;

  always @(posedge clk) begin
    if (reset) begin
      q.delete();
      busy   = 1'b0;
      waited = 0;
      e_gn   = 1'b0;
      e_to   = 1'b0;
      e_uf   = 1'b0;
    end else begin
      occ    = q.size();
      e_gn   = 1'b0;
      e_to   = 1'b0;
      e_uf   = 1'b0;
      m_push = 1'b0;
      m_val  = 16'h0000;
      if (!busy) begin
        if (occ < DEPTH) begin
          e_gn   = 1'b1;
          busy   = 1'b1;
          waited = 0;
        end
      end else if (sample_ready) begin
        m_push = 1'b1;
        m_val  = sample;
        busy   = 1'b0;
      end else begin
        waited++;
        if (waited == TIMEOUT) begin
          m_push = 1'b1;
          e_to   = 1'b1;
          busy   = 1'b0;
        end
      end
      if (codec_req) begin
        if (occ > 0) void'(q.pop_front());
        else e_uf = 1'b1;
      end
      if (m_push) q.push_back(m_val);
    end
  end

  logic chk_en = 1'b0;

  always @(negedge clk) begin
    if (chk_en) begin
      check("m_generate_next", 32'(generate_next), 32'(e_gn));
      check("m_codec_valid", 32'(codec_valid), 32'(q.size() != 0));
      check("m_codec_sample", 32'(codec_sample), 32'((q.size() != 0) ? q[0] : 16'h0000));
      check("m_timeout_err", 32'(timeout_err), 32'(e_to));
      check("m_underflow", 32'(underflow), 32'(e_uf));
    end
  end

  // ---------------- directed stimulus ----------------
  int cyc = 0;

  task automatic step();
    @(negedge clk);
    cyc++;
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    for (int i = 0; i < n; i++) step();
    reset = 1'b0;
    cyc   = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    reset     = 1'b1;
    codec_req = 1'b0;
    step();
    step();
    check("rst_generate_next", 32'(generate_next), 32'd0);
    check("rst_codec_valid", 32'(codec_valid), 32'd0);
    check("rst_codec_sample", 32'(codec_sample), 32'd0);
    check("rst_timeout_err", 32'(timeout_err), 32'd0);
    check("rst_underflow", 32'(underflow), 32'd0);
    chk_en = 1'b1;

    // Fill: requests at 1,5,9,13, data from cycle 4, stops when full.
    reset = 1'b0;
    cyc   = 0;
    for (int k = 1; k <= 24; k++) begin
      step();
      check("fill_generate_next", 32'(generate_next),
            32'((k == 1) || (k == 5) || (k == 9) || (k == 13)));
      check("fill_codec_valid", 32'(codec_valid), 32'(k >= 4));
    end
    check("fill_head", 32'(codec_sample), 32'h0001);

    // Order/refill: pops spaced 10 cycles, refill request 2 cycles after pop.
    for (int i = 0; i < 4; i++) begin
      step();
      codec_req = 1'b1;
      check("order_head", 32'(codec_sample), 32'(i + 1));
      step();
      codec_req = 1'b0;
      step();
      check("refill_generate_next", 32'(generate_next), 32'd1);
      for (int j = 0; j < 7; j++) step();
    end
    check("refill_head", 32'(codec_sample), 32'h0005);

    // Underflow then timeout with a silent generator.
    gen_en = 1'b0;
    do_reset(2);
    step();
    check("uf_generate_next", 32'(generate_next), 32'd1);
    step();
    codec_req = 1'b1;
    step();
    codec_req = 1'b0;
    check("uf_underflow", 32'(underflow), 32'd1);
    check("uf_codec_valid", 32'(codec_valid), 32'd0);
    check("uf_codec_sample", 32'(codec_sample), 32'd0);
    while (cyc < 8) step();
    stray_fire = 1'b1;
    stray_val  = 16'hBEEF;
    check("to_timeout_err", 32'(timeout_err), 32'd1);
    check("to_codec_valid", 32'(codec_valid), 32'd1);
    check("to_silence", 32'(codec_sample), 32'h0000);
    step();
    stray_fire = 1'b0;
    check("to_generate_next", 32'(generate_next), 32'd1);
    codec_req = 1'b1;
    step();
    codec_req = 1'b0;
    check("stray_ignored", 32'(codec_valid), 32'd0);
    // Response on the expiry cycle (7th WAIT cycle) wins over the timeout.
    while (cyc < 15) step();
    stray_fire = 1'b1;
    stray_val  = 16'h0777;
    step();
    stray_fire = 1'b0;
    check("tie_timeout_err", 32'(timeout_err), 32'd0);
    check("tie_codec_sample", 32'(codec_sample), 32'h0777);

    // Simultaneous push/pop with one entry held.
    gen_en    = 1'b1;
    gen_base  = 16'h0005;
    gen_epoch = gen_epoch + 1;
    do_reset(2);
    while (cyc < 7) step();
    check("pp_head_before", 32'(codec_sample), 32'h0005);
    codec_req = 1'b1;
    step();
    codec_req = 1'b0;
    check("pp_codec_valid", 32'(codec_valid), 32'd1);
    check("pp_head_after", 32'(codec_sample), 32'h0006);
    check("pp_underflow", 32'(underflow), 32'd0);

    // Reset the cycle after the request; the late response is ignored.
    gen_base  = 16'h0010;
    gen_epoch = gen_epoch + 1;
    do_reset(2);
    step();
    check("mid_generate_next", 32'(generate_next), 32'd1);
    step();
    reset = 1'b1;
    step();
    check("mid_rst_generate_next", 32'(generate_next), 32'd0);
    check("mid_rst_codec_valid", 32'(codec_valid), 32'd0);
    check("mid_rst_codec_sample", 32'(codec_sample), 32'd0);
    reset = 1'b0;
    cyc   = 0;
    step();
    check("mid_restart_generate_next", 32'(generate_next), 32'd1);
    step();
    step();
    check("mid_codec_valid_c3", 32'(codec_valid), 32'd0);
    step();
    check("mid_codec_valid_c4", 32'(codec_valid), 32'd1);
    check("mid_head", 32'(codec_sample), 32'h0011);
    for (int j = 0; j < 6; j++) step();

    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
